// File: rtl/sat_narrower_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sat_narrower_pkg
//  Brief   : Shared datapath widths and narrow-field limit constants.
//  Rev     : 1.0  initial release
// ============================================================================
package sat_narrower_pkg;

    localparam int REGISTER_DATA_BIT_WIDTH = 16;
    localparam int DATA_2_WIDTH            = 4;

    // Extreme representable values of the narrow signed field
    localparam logic [DATA_2_WIDTH-1:0] NARROW_MAX = {1'b0, {(DATA_2_WIDTH-1){1'b1}}};
    localparam logic [DATA_2_WIDTH-1:0] NARROW_MIN = {1'b1, {(DATA_2_WIDTH-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/sat_narrower_if.sv
`default_nettype none
// ============================================================================
//  Module  : sat_narrower_if
//  Brief   : Input/output valid-ready streams of the narrowing stage.
//  Rev     : 1.0  initial release
// ============================================================================
interface sat_narrower_if
    import sat_narrower_pkg::*;
#(
    parameter int REG_W = REGISTER_DATA_BIT_WIDTH,
    parameter int NAR_W = DATA_2_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [REG_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [NAR_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/sat_narrower_narrow_fit_check.sv
`default_nettype none
// ============================================================================
//  Module  : narrow_fit_check
//  Brief   : Combinational fit test and narrowing mux (wrap or clamp).
//            Clamping enabled by macro SAT_NARROWER_SATURATE_EN.
//  Rev     : 1.0  initial release
// ============================================================================
module narrow_fit_check
    import sat_narrower_pkg::*;
#(
    parameter int REGISTER_DATA_BIT_WIDTH = sat_narrower_pkg::REGISTER_DATA_BIT_WIDTH,
    parameter int DATA_2_WIDTH            = sat_narrower_pkg::DATA_2_WIDTH
) (
    input  wire logic [REGISTER_DATA_BIT_WIDTH-1:0] i_data,
    output logic                                    o_fits,
    output logic [DATA_2_WIDTH-1:0]                 o_data
);
    localparam logic [DATA_2_WIDTH-1:0] c_NARROW_MAX = {1'b0, {(DATA_2_WIDTH-1){1'b1}}};
    localparam logic [DATA_2_WIDTH-1:0] c_NARROW_MIN = {1'b1, {(DATA_2_WIDTH-1){1'b0}}};

    // Bits that must all equal the narrow sign bit for a lossless narrow
    logic [REGISTER_DATA_BIT_WIDTH-DATA_2_WIDTH:0] w_upper;

    assign w_upper = i_data[REGISTER_DATA_BIT_WIDTH-1:DATA_2_WIDTH-1];
    assign o_fits  = (&w_upper) || (~|w_upper);

`ifdef SAT_NARROWER_SATURATE_EN
    assign o_data = o_fits ? i_data[DATA_2_WIDTH-1:0]
                  : (i_data[REGISTER_DATA_BIT_WIDTH-1] ? c_NARROW_MIN : c_NARROW_MAX);
`else
    logic [DATA_2_WIDTH-1:0] w_unused_lim;
    assign w_unused_lim = c_NARROW_MAX ^ c_NARROW_MIN;
    assign o_data       = i_data[DATA_2_WIDTH-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/sat_narrower.sv
`default_nettype none
// ============================================================================
//  Module  : sat_narrower
//  Brief   : Registered valid/ready stage narrowing a signed word, with
//            sticky overflow flag and saturating overflow event counter.
//            Optional clamping via macro SAT_NARROWER_SATURATE_EN.
//  Rev     : 1.0  initial release
// ============================================================================
module sat_narrower
    import sat_narrower_pkg::*;
#(
    parameter int REGISTER_DATA_BIT_WIDTH = sat_narrower_pkg::REGISTER_DATA_BIT_WIDTH,
    parameter int DATA_2_WIDTH            = sat_narrower_pkg::DATA_2_WIDTH,
    parameter int COUNT_WIDTH             = 8
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    sat_narrower_if.slave               bus,
    input  wire logic                   clr_sticky,
    output logic                        sticky_ovf,
    output logic [COUNT_WIDTH-1:0]      ovf_count
);
    localparam logic [COUNT_WIDTH-1:0] c_COUNT_MAX = '1;

    logic                    w_fits;
    logic [DATA_2_WIDTH-1:0] w_narrow;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_ovf_event;

    logic                    r_out_valid;
    logic [DATA_2_WIDTH-1:0] r_out_data;
    logic                    r_out_ovf;
    logic                    r_sticky;
    logic [COUNT_WIDTH-1:0]  r_count;

    narrow_fit_check #(
        .REGISTER_DATA_BIT_WIDTH (REGISTER_DATA_BIT_WIDTH),
        .DATA_2_WIDTH            (DATA_2_WIDTH)
    ) u_fit (
        .i_data (bus.in_data),
        .o_fits (w_fits),
        .o_data (w_narrow)
    );

    assign w_in_ready  = !r_out_valid || bus.out_ready;
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_ovf_event = w_accept && !w_fits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_sticky    <= 1'b0;
            r_count     <= '0;
        end else begin
            if (w_in_ready) begin
                r_out_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_out_data <= w_narrow;
                    r_out_ovf  <= !w_fits;
                end
            end
            // A clear coinciding with an event restarts the count at one
            if (w_ovf_event) begin
                r_sticky <= 1'b1;
                if (clr_sticky)
                    r_count <= COUNT_WIDTH'(1);
                else if (r_count != c_COUNT_MAX)
                    r_count <= r_count + 1'b1;
            end else if (clr_sticky) begin
                r_sticky <= 1'b0;
                r_count  <= '0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ovf   = r_out_ovf;
    assign sticky_ovf    = r_sticky;
    assign ovf_count     = r_count;

endmodule
`default_nettype wire

// File: doc/sat_narrower.md
Name: sat_narrower

Overview:
- Inverse of the datapath's sign-extension stage: narrows a REGISTER_DATA_BIT_WIDTH signed value to a DATA_2_WIDTH signed field, e.g. for immediate/offset write-back or narrow store.
- Detects values that do not fit the narrow field.
- Registered, valid/ready handshaked stage that sits between ALU result and narrow consumers.
- Keeps a sticky overflow flag and an overflow event counter for debug/status.

Parameters:
- REGISTER_DATA_BIT_WIDTH, 16, width of the signed input word.
- DATA_2_WIDTH, 4, width of the signed narrow output; must be >= 2 and < REGISTER_DATA_BIT_WIDTH.
- COUNT_WIDTH, 8, width of the overflow event counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data valid.
- in_ready  output  1  stage can accept in_data this cycle.
- in_data  input  REGISTER_DATA_BIT_WIDTH  signed value to narrow.
- out_valid  output  1  out_data/out_ovf valid.
- out_ready  input  1  consumer accepts output this cycle.
- out_data  output  DATA_2_WIDTH  narrowed signed result.
- out_ovf  output  1  this result did not fit (qualified by out_valid).
- clr_sticky  input  1  synchronous clear of sticky_ovf and ovf_count.
- sticky_ovf  output  1  set on any accepted overflow since the last clear.
- ovf_count  output  COUNT_WIDTH  number of accepted overflows, saturating at all-ones.

Behaviour:
- Reset is asynchronous and active-high, on one clock. While reset is high: out_valid=0, out_data=0, out_ovf=0, sticky_ovf=0, ovf_count=0. An in-flight result is dropped.
- Fit rule: in_data fits iff bits [REGISTER_DATA_BIT_WIDTH-1 : DATA_2_WIDTH-1] are all equal, i.e. sign-extending the narrow value reproduces in_data.
  - fits -> out_data = in_data[DATA_2_WIDTH-1:0], out_ovf=0.
  - not fit -> out_ovf=1; out_data as set by the optional feature.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; one output register, no skid).
  - Transfer in on in_valid && in_ready. Result is registered, so out_valid rises the next cycle: latency 1.
  - Output is held stable while out_valid && !out_ready.
  - out_valid falls after out_ready unless a new input transfers in the same cycle. Back-to-back throughput is 1 per cycle.
- Overflow accounting counts only accepted inputs that overflow (input-side event):
  - sticky_ovf is set.
  - ovf_count increments and holds at 2^COUNT_WIDTH-1 without wrapping.
- clr_sticky in the same cycle as an accepted overflow: the clear applies first, then the event is counted, giving sticky_ovf=1 and ovf_count=1.
- in_valid while !in_ready: input is not consumed and no accounting happens; the producer must hold it.

Optional Feature:
- Macro: SAT_NARROWER_SATURATE_EN.
- Defined: on overflow, out_data clamps to the narrow range:
  - max positive (0 followed by all 1s) if in_data is non-negative;
  - min negative (1 followed by all 0s) if in_data is negative.
- Undefined: on overflow, out_data = in_data[DATA_2_WIDTH-1:0] (plain wrap). out_ovf, sticky_ovf and ovf_count behave identically in both builds.

Decomposition:
- Shared package holds REGISTER_DATA_BIT_WIDTH and DATA_2_WIDTH defaults (shared with the sign extender) and helper constants NARROW_MAX / NARROW_MIN derived from DATA_2_WIDTH.
- One natural combinational sub-module, narrow_fit_check: in_data -> {fits, narrowed value}, including the saturation mux.
- The top level holds the pipeline register, handshake and counters.

Test Plan:
- Reset mid-transfer: reset asserted while out_valid=1 and out_ready=0 -> out_valid=0 immediately (asynchronous), and sticky_ovf/ovf_count=0.
- Boundaries, with out_ready=1 and one input per cycle:
  - 0x0007 -> 7, ovf=0
  - 0xFFF8 -> 0x8, ovf=0
  - 0x0008 -> 0x7 with saturation / 0x8 without, ovf=1
  - 0xFFF7 -> 0x8 with saturation / 0x7 without, ovf=1
  - each appears 1 cycle after acceptance.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0; out_data is held. Releasing out_ready accepts the next input in the same cycle with no gap.
- Counter saturation (COUNT_WIDTH=2): 5 accepted overflows -> ovf_count=3, sticky_ovf=1. Held (non-accepted) overflow inputs do not count.
- Simultaneous clr_sticky with an accepted 0x7FFF -> ovf_count=1, sticky_ovf=1 next cycle. clr_sticky alone -> both 0.
